// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between the MEM stage and a debug port, with a bounded wait for debug.
// Build with DMEM_ARB_STATS_EN defined to add the stall_cycles and dbg_grants counters.
module dmem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [3:0]        cpu_sel,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_sel,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       dbg_grants
`endif
);
    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, PEND, ACK} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] starve_cnt, starve_nx;
    logic          grant;

    always_comb begin
        grant     = (state == PEND) && (!cpu_req || starve_cnt == SMAX);
        state_nx  = state;
        starve_nx = starve_cnt;
        case (state)
            IDLE: if (dbg_req) begin
                state_nx  = PEND;
                starve_nx = '0;
            end
            PEND: if (grant) state_nx = ACK;
                  else starve_nx = starve_cnt + 1'b1;
            default: state_nx = IDLE;
        endcase
    end

    // rst gates the write strobe so an aborted transaction never reaches memory
    assign mem_addr  = grant ? dbg_addr : cpu_addr;
    assign mem_sel   = grant ? 4'b1111 : cpu_sel;
    assign mem_din   = grant ? dbg_wdata : cpu_wdata;
    assign mem_we    = !rst && (grant ? dbg_we : (cpu_req && cpu_we));
    assign cpu_stall = !rst && grant && cpu_req;
    assign cpu_rdata = mem_dout;
    assign dbg_ack   = (state == ACK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            dbg_rdata  <= '0;
        end else begin
            state      <= state_nx;
            starve_cnt <= starve_nx;
            if (grant) dbg_rdata <= mem_dout;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            dbg_grants   <= '0;
        end else begin
            if (cpu_stall) stall_cycles <= stall_cycles + 32'd1;
            if (grant) dbg_grants <= dbg_grants + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter with a behavioural byte-enabled memory.
// Instantiates STARVE_MAX=4 and STARVE_MAX=0 variants; counter checks need DMEM_ARB_STATS_EN.
module tb_dmem_arbiter;
    logic        clk = 0;
    logic        rst, cpu_req, cpu_we, dbg_req, dbg_we;
    logic [9:0]  cpu_addr, dbg_addr;
    logic [3:0]  cpu_sel;
    logic [31:0] cpu_wdata, dbg_wdata;
    logic [31:0] cpu_rdata, dbg_rdata, mem_din, mem_dout;
    logic        cpu_stall, dbg_ack, mem_we;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_sel;
    logic [31:0] s_cpu_rdata, s_dbg_rdata, s_din, s_dout;
    logic        s_stall, s_ack, s_we;
    logic [9:0]  s_addr;
    logic [3:0]  s_sel;
    logic [31:0] mem [0:1023];
    int          errors = 0, checks = 0;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stall_cycles, dbg_grants, s_stall_cycles, s_dbg_grants;
`endif

    always #5 clk = ~clk;

    assign mem_dout = mem[mem_addr];
    assign s_dout   = mem[s_addr];

    always @(posedge clk)
        if (mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_sel[b]) mem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_sel(cpu_sel), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .mem_addr(mem_addr), .mem_sel(mem_sel),
        .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
`ifdef DMEM_ARB_STATS_EN
        , .stall_cycles(stall_cycles), .dbg_grants(dbg_grants)
`endif
    );

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_MAX(0)) dut0 (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_sel(cpu_sel), .cpu_wdata(cpu_wdata), .cpu_rdata(s_cpu_rdata), .cpu_stall(s_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(s_ack), .dbg_rdata(s_dbg_rdata), .mem_addr(s_addr), .mem_sel(s_sel),
        .mem_din(s_din), .mem_we(s_we), .mem_dout(s_dout)
`ifdef DMEM_ARB_STATS_EN
        , .stall_cycles(s_stall_cycles), .dbg_grants(s_dbg_grants)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_store(input logic [9:0] a, input logic [3:0] s, input logic [31:0] d);
        cpu_req = 1; cpu_we = 1; cpu_addr = a; cpu_sel = s; cpu_wdata = d;
        #1;
        chk("st_we", {31'b0, mem_we}, 32'd1);
        chk("st_stall", {31'b0, cpu_stall}, 32'd0);
        cyc();
        cpu_req = 0; cpu_we = 0;
    endtask

    // CPU loads every cycle while debug writes d to addr 9
    task automatic run_s2(input logic [31:0] d);
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'd7; cpu_sel = 4'hf;
        dbg_req = 1; dbg_we = 1; dbg_addr = 10'd9; dbg_wdata = d;
        #1;
        chk("s2_c0_stall", {31'b0, cpu_stall}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("s2_cpu_addr", {22'b0, mem_addr}, 32'd7);
            chk("s2_cpu_stall", {31'b0, cpu_stall}, 32'd0);
            chk("s2_cpu_we", {31'b0, mem_we}, 32'd0);
        end
        cyc();
        chk("s2_g_we", {31'b0, mem_we}, 32'd1);
        chk("s2_g_addr", {22'b0, mem_addr}, 32'd9);
        chk("s2_g_sel", {28'b0, mem_sel}, 32'hf);
        chk("s2_g_din", mem_din, d);
        chk("s2_g_stall", {31'b0, cpu_stall}, 32'd1);
        chk("s2_g_ack", {31'b0, dbg_ack}, 32'd0);
        cyc();
        chk("s2_ack", {31'b0, dbg_ack}, 32'd1);
        chk("s2_ack_stall", {31'b0, cpu_stall}, 32'd0);
        chk("s2_ack_addr", {22'b0, mem_addr}, 32'd7);
        dbg_req = 0; cpu_req = 0;
        cyc();
        chk("s2_ack_drop", {31'b0, dbg_ack}, 32'd0);
        chk("s2_mem9", mem[9], d);
    endtask

    task automatic reset_pulse();
        rst = 1;
        cyc();
        cyc();
        rst = 0;
    endtask

    initial begin
        rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_sel = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        cyc();
        cyc();
        chk("rst_ack", {31'b0, dbg_ack}, 32'd0);
        chk("rst_rdata", dbg_rdata, 32'd0);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_stall", {31'b0, cpu_stall}, 32'd0);
`ifdef DMEM_ARB_STATS_EN
        chk("rst_stall_cycles", stall_cycles, 32'd0);
        chk("rst_dbg_grants", dbg_grants, 32'd0);
`endif
        rst = 0;
        cpu_store(10'd5, 4'hf, 32'hDEADBEEF);
        cpu_store(10'd11, 4'hf, 32'h0);
        cpu_req = 1; cpu_we = 1; cpu_addr = 10'd3; cpu_sel = 4'b0010; cpu_wdata = 32'h0000AB00;
        #1;
        chk("s4_we", {31'b0, mem_we}, 32'd1);
        chk("s4_sel", {28'b0, mem_sel}, 32'b0010);
        chk("s4_addr", {22'b0, mem_addr}, 32'd3);
        chk("s4_din", mem_din, 32'h0000AB00);
        chk("s4_stall", {31'b0, cpu_stall}, 32'd0);
        cyc();
        cpu_req = 0; cpu_we = 0; cpu_addr = 10'd5;
        #1;
        chk("s4_mem3", {24'b0, mem[3][15:8]}, 32'hAB);
        chk("cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        cpu_addr = 10'd0;
        dbg_req = 1; dbg_we = 0; dbg_addr = 10'd5;
        #1;
        chk("s1_c0_addr", {22'b0, mem_addr}, 32'd0);
        chk("s1_c0_stall", {31'b0, cpu_stall}, 32'd0);
        cyc();
        chk("s1_c1_addr", {22'b0, mem_addr}, 32'd5);
        chk("s1_c1_we", {31'b0, mem_we}, 32'd0);
        chk("s1_c1_ack", {31'b0, dbg_ack}, 32'd0);
        chk("s1_c1_stall", {31'b0, cpu_stall}, 32'd0);
        cyc();
        chk("s1_c2_ack", {31'b0, dbg_ack}, 32'd1);
        chk("s1_c2_rdata", dbg_rdata, 32'hDEADBEEF);
        chk("s1_c2_stall", {31'b0, cpu_stall}, 32'd0);
        dbg_req = 0;
        cyc();
        chk("s1_c3_ack", {31'b0, dbg_ack}, 32'd0);
        chk("s1_c3_hold", dbg_rdata, 32'hDEADBEEF);
        run_s2(32'h12345678);
`ifdef DMEM_ARB_STATS_EN
        chk("st_stall_1", stall_cycles, 32'd1);
        chk("st_grants_2", dbg_grants, 32'd2);
`endif
        reset_pulse();
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'd7;
        dbg_req = 1; dbg_we = 0; dbg_addr = 10'd5;
        #1;
        chk("s3_c0_stall", {31'b0, s_stall}, 32'd0);
        cyc();
        chk("s3_c1_stall", {31'b0, s_stall}, 32'd1);
        chk("s3_c1_addr", {22'b0, s_addr}, 32'd5);
        chk("s3_c1_we", {31'b0, s_we}, 32'd0);
        chk("s3_c1_sel", {28'b0, s_sel}, 32'hf);
        cyc();
        chk("s3_c2_ack", {31'b0, s_ack}, 32'd1);
        chk("s3_c2_rdata", s_dbg_rdata, 32'hDEADBEEF);
        chk("s3_c2_stall", {31'b0, s_stall}, 32'd0);
        chk("s3_c2_addr", {22'b0, s_addr}, 32'd7);
        chk("s3_c2_din", s_din, cpu_wdata);
        chk("s3_c2_crd", s_cpu_rdata, mem[7]);
        reset_pulse();
        cpu_req = 0; dbg_req = 1; dbg_we = 1; dbg_addr = 10'd11; dbg_wdata = 32'hA5A5A5A5;
        cyc();
        chk("s5_pre_we", {31'b0, mem_we}, 32'd1);
        rst = 1;
        #1;
        chk("s5_rst_we", {31'b0, mem_we}, 32'd0);
        chk("s5_rst_stall", {31'b0, cpu_stall}, 32'd0);
        cyc();
        dbg_req = 0;
        chk("s5_ack", {31'b0, dbg_ack}, 32'd0);
        chk("s5_rdata", dbg_rdata, 32'd0);
        rst = 0;
        cyc();
        chk("s5_ack_after", {31'b0, dbg_ack}, 32'd0);
        chk("s5_mem11", mem[11], 32'd0);
`ifdef DMEM_ARB_STATS_EN
        chk("s6_rst_stall", stall_cycles, 32'd0);
        chk("s6_rst_grants", dbg_grants, 32'd0);
`endif
        run_s2(32'h12345678);
        run_s2(32'h9ABCDEF0);
`ifdef DMEM_ARB_STATS_EN
        chk("s6_stall", stall_cycles, 32'd2);
        chk("s6_grants", dbg_grants, 32'd2);
        reset_pulse();
        chk("s6_clr_stall", stall_cycles, 32'd0);
        chk("s6_clr_grants", dbg_grants, 32'd0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
